// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// Latency: the accept edge puts START on the line; one frame bit per clk; outputs registered.
// Backpressure: none; data_valid outside IDLE is dropped and busy tells upstream to hold off.
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [1:0]            mux_n;
    logic                  busy_n;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         cnt;
    logic                  par_en_q;
    logic                  accept;
    logic                  shift_en;

    assign accept   = (state == IDLE) && data_valid;
    assign shift_en = (state == START) || ((state == DATA) && (cnt != LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mux_sel <= 2'b11;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            mux_sel <= mux_n;
            busy    <= busy_n;
        end
    end

    // mux_sel/busy are registered copies of the next-state decode.
    always_comb begin
        state_n = state;
        mux_n   = 2'b11;
        busy_n  = 1'b1;
        case (state)
            IDLE:    if (data_valid) state_n = START;
            START:   state_n = DATA;
            DATA:    if (cnt == LAST) state_n = par_en_q ? PARITY : STOP;
            PARITY:  state_n = STOP;
            STOP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        case (state_n)
            IDLE:    begin mux_n = 2'b11; busy_n = 1'b0; end
            START:   mux_n = 2'b00;
            DATA:    mux_n = 2'b01;
            PARITY:  mux_n = 2'b10;
            default: mux_n = 2'b11;
        endcase
    end

    // The START->DATA edge loads bit 0 and clears the counter; each DATA edge
    // advances one bit until the last one, after which ser_data just holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt       <= '0;
            par_en_q  <= 1'b0;
            par_bit   <= 1'b0;
            ser_data  <= 1'b0;
        end else if (accept) begin
            shift_reg <= p_data;
            par_en_q  <= par_en;
            par_bit   <= (^p_data) ^ par_typ;
            cnt       <= '0;
        end else if (shift_en) begin
            ser_data  <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            cnt       <= (state == START) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- Upstream control and serializer stage of the UART transmitter.
- Accepts a parallel byte, sequences the frame: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
- Drives the TX output mux with mux_sel, ser_data and par_bit.
- Mux encoding it targets: 00 start (0), 01 ser_data, 10 parity, 11 stop/idle (1).
- Timing base: one frame bit per clk cycle; clk is the baud-rate clock.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (supported range 5..8).

Ports:
- clk  input  1  baud-rate clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- p_data  input  DATA_WIDTH  parallel byte to transmit.
- data_valid  input  1  request; p_data is valid this cycle.
- par_en  input  1  1 = insert parity bit after data.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- mux_sel  output  2  selects the TX line source: 00 start, 01 data, 10 parity, 11 stop/idle.
- ser_data  output  1  current data bit, LSB first.
- par_bit  output  1  parity of the latched byte.
- busy  output  1  high while a frame is on the line.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (asserted, async) values:
  - state = IDLE; mux_sel = 2'b11; busy = 0; ser_data = 0; par_bit = 0.
  - Bit counter and data/config registers = 0.
- Outputs: all registered; no combinational path from inputs to outputs.
- States and mux_sel per state:
  - IDLE: mux_sel = 11, busy = 0.
  - START: mux_sel = 00, busy = 1.
  - DATA: mux_sel = 01, busy = 1.
  - PARITY: mux_sel = 10, busy = 1.
  - STOP: mux_sel = 11, busy = 1.
- Accept:
  - Condition: rising edge with state = IDLE and data_valid = 1.
  - Latch p_data into the shift register; latch par_en and par_typ.
  - Compute par_bit = ^p_data XOR par_typ (even: XOR of bits; odd: its inverse).
  - Go to START.
- Ignored requests:
  - data_valid in any non-IDLE state is ignored; no queuing.
  - Changes to par_en or par_typ mid-frame have no effect.
- Transitions:
  - START -> DATA after 1 cycle; bit counter = 0; ser_data = shift_reg[0].
  - DATA: each cycle, shift right and increment the counter; ser_data = next bit.
  - DATA exit: after DATA_WIDTH cycles (counter reaches DATA_WIDTH-1), go to PARITY if the latched par_en = 1, otherwise STOP.
  - PARITY -> STOP after 1 cycle.
  - STOP -> IDLE after 1 cycle.
- Latency and frame length:
  - Accept edge k gives START at cycle k+1; busy rises at the same edge.
  - Frame = 1 + DATA_WIDTH + par_en + 1 cycles (10 or 11 for 8 bits).
  - busy falls on the edge entering IDLE.
  - Back-to-back: a request held high is accepted on the first IDLE cycle, so the minimum line-high gap between frames is STOP + 1 IDLE cycle = 2 cycles.
- Counter: log2-sized, no wrap beyond DATA_WIDTH-1; DATA never exceeds DATA_WIDTH cycles.
- Outside DATA: ser_data holds its last value and is don't-care to the mux; par_bit holds until the next accept.
- Reset mid-frame: frame abandoned immediately (async). Line returns to stop level (mux_sel = 11), busy = 0; no partial resumption after release.
- Reset released with data_valid = 1: accepted on the first rising edge after release.

Test Plan:
- Reset then idle: mux_sel = 11, busy = 0 for 20 cycles with data_valid = 0.
- p_data = 8'hA5, par_en = 0, one-cycle data_valid:
  - mux_sel sequence 00, 01 x8, 11, then idle.
  - ser_data = 1,0,1,0,0,1,0,1.
  - busy high exactly 10 cycles.
- p_data = 8'h07, par_en = 1, par_typ = 0: par_bit = 1, 11-cycle frame with mux_sel = 10 in cycle 10. Repeat with par_typ = 1: par_bit = 0.
- data_valid held high with p_data = 8'h3C then 8'hC3 (changing mid-frame):
  - First frame carries 3C unchanged.
  - Second frame accepted exactly 2 cycles after the first frame's STOP begins.
- Reset asserted during data bit 4 of 8'hFF: mux_sel = 11 and busy = 0 immediately (before the next edge); after release no bits are emitted until a new data_valid.
- par_en toggled 1 -> 0 during DATA of a par_en = 1 frame: PARITY state still emitted (latched configuration used).
